csa_accum: RTL and testbench

CSA_ACCUM -- requirements
Module: csa_accum

---
 rtl/csa_pkg.sv | 22 ++
 rtl/csa_slice4.sv | 23 ++
 rtl/csa_accum.sv | 139 +++++++++++++
 tb/tb_csa_accum.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-select accumulator: state encoding,
// slice width and the signed-overflow helper.
package csa_pkg;

  // Width of one carry-select adder slice.
  localparam int SLICE_W = 4;

  // Burst state of the accumulator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // accumulator is zero, no burst open
    ACC  = 2'd1,  // burst open, operands being summed
    DONE = 2'd2   // burst result held for the consumer
  } state_t;

  // Two's-complement overflow: the addends agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/csa_slice4.sv
// One 4-bit carry-select adder slice: both carry-in outcomes are computed
// in parallel and the incoming carry only drives the final select.
module csa_slice4
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  logic [SLICE_W:0] sum_c0;
  logic [SLICE_W:0] sum_c1;

  // Precompute the slice result for carry-in 0 and carry-in 1, then select.
  always_comb begin
    sum_c0 = {1'b0, a_i} + {1'b0, b_i};
    sum_c1 = {1'b0, a_i} + {1'b0, b_i} + (SLICE_W + 1)'(1);
    {cout_o, sum_o} = cin_i ? sum_c1 : sum_c0;
  end

endmodule

// File: rtl/csa_accum.sv
// Burst accumulator built on a chain of carry-select slices.
// Operands arrive over a valid/ready port and are added or subtracted into
// the accumulator; the operand flagged last closes the burst and the total,
// final carry-out and sticky signed overflow are presented on the result port.
// Optional feature: define CSA_ACCUM_SAT_EN to clamp the accumulator on
// signed overflow instead of wrapping.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the source holds valid (and its payload) until that edge, ready may
// depend on state only, and neither side may retract valid before transfer.
module csa_accum
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output state_t           dbg_state
);

  localparam int NSLICE = WIDTH / SLICE_W;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("csa_accum: WIDTH must be a positive multiple of 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] next_acc;
  logic [NSLICE:0]  carry;
  logic             add_ovf;
  logic             in_xfer;

  // Subtraction is acc + ~data + 1: invert here, the +1 enters as slice-0 carry-in.
  assign operand  = in_sub ? ~in_data : in_data;
  // A burst always starts from zero, whatever the register holds.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;
  assign carry[0] = in_sub;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    csa_slice4 u_slice (
      .a_i   (acc_base[i*SLICE_W +: SLICE_W]),
      .b_i   (operand[i*SLICE_W +: SLICE_W]),
      .cin_i (carry[i]),
      .sum_o (raw_sum[i*SLICE_W +: SLICE_W]),
      .cout_o(carry[i+1])
    );
  end

  assign add_ovf = signed_ovf(acc_base[WIDTH-1], operand[WIDTH-1], raw_sum[WIDTH-1]);

`ifdef CSA_ACCUM_SAT_EN
  // Clamp toward the sign of the addends: both positive -> max, both negative -> min.
  always_comb begin
    next_acc = raw_sum;
    if (add_ovf) begin
      next_acc = operand[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // Plain modulo-2^WIDTH wrap.
  always_comb begin
    next_acc = raw_sum;
  end
`endif

  assign in_ready  = (state_q != DONE);
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

  // Next-state and datapath update: absorb operands, hold the result, release on accept.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACC: begin
        if (in_xfer) begin
          acc_d   = next_acc;
          cout_d  = carry[NSLICE];
          ovf_d   = ((state_q == IDLE) ? 1'b0 : ovf_q) | add_ovf;
          state_d = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and result registers; reset discards any open or held burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Directed bench for csa_accum (WIDTH=16). Honors CSA_ACCUM_SAT_EN for the
// overflow expectations.
module tb_csa_accum;
  import csa_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sub;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  csa_accum #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one operand and hold it until the transfer edge; returns #1 after that edge.
  task automatic xfer(input logic [W-1:0] d, input logic s, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] s,
                            input logic c, input logic o);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"},   {16'd0, out_sum},   {16'd0, s});
    chk({tag, "_cout"},  {31'd0, out_cout},  {31'd0, c});
    chk({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, o});
  endtask

  // Accept the held result and confirm return to IDLE.
  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_idle"},  {30'd0, dbg_state}, {30'd0, IDLE});
    chk({tag, "_vlow"},  {31'd0, out_valid}, 32'd0);
  endtask

  logic [W-1:0] exp_ovf_sum;
  logic [W-1:0] exp_neg_sum;
  logic [W-1:0] held_sum;

  initial begin
`ifdef CSA_ACCUM_SAT_EN
    exp_ovf_sum = 16'h7FFF;
    exp_neg_sum = 16'h8000;
`else
    exp_ovf_sum = 16'h8000;
    exp_neg_sum = 16'h7FFF;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready},  32'd1);
    chk("rst_sum",   {16'd0, out_sum},   32'd0);
    chk("rst_cout",  {31'd0, out_cout},  32'd0);
    chk("rst_ovf",   {31'd0, out_ovf},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add burst with a gap inside: 3 + 4 + 5 = 0x000C
    xfer(16'h0003, 1'b0, 1'b0);
    chk("add_acc", {30'd0, dbg_state}, {30'd0, ACC});
    @(posedge clk);
    #1;
    chk("gap_acc", {30'd0, dbg_state}, {30'd0, ACC});
    xfer(16'h0004, 1'b0, 1'b0);
    xfer(16'h0005, 1'b0, 1'b1);
    chk_result("add", 16'h000C, 1'b0, 1'b0);
    accept("add");

    // Subtract with borrow: 5 - 7 = 0xFFFE, no carry-out
    xfer(16'h0005, 1'b0, 1'b0);
    xfer(16'h0007, 1'b1, 1'b1);
    chk_result("sub", 16'hFFFE, 1'b0, 1'b0);
    accept("sub");

    // Subtracting first operand starts from zero: -3 = 0xFFFD
    xfer(16'h0003, 1'b1, 1'b1);
    chk_result("neg1st", 16'hFFFD, 1'b0, 1'b0);
    accept("neg1st");

    // Positive signed overflow
    xfer(16'h7FFF, 1'b0, 1'b0);
    xfer(16'h0001, 1'b0, 1'b1);
    chk_result("povf", exp_ovf_sum, 1'b0, 1'b1);
    accept("povf");

    // Overflow stays sticky through a later non-overflowing add
    xfer(16'h7FFF, 1'b0, 1'b0);
    xfer(16'h0001, 1'b0, 1'b0);
    xfer(16'h0000, 1'b0, 1'b1);
    chk_result("sticky", exp_ovf_sum, 1'b0, 1'b1);
    accept("sticky");

    // Negative signed overflow: 0x8000 - 1
    xfer(16'h8000, 1'b0, 1'b0);
    xfer(16'h0001, 1'b1, 1'b1);
    chk_result("novf", exp_neg_sum, 1'b1, 1'b1);
    accept("novf");

    // Full carry chain: 0xFFFF + 1
    xfer(16'hFFFF, 1'b0, 1'b0);
    xfer(16'h0001, 1'b0, 1'b1);
    chk_result("chain", 16'h0000, 1'b1, 1'b0);
    accept("chain");

    // Backpressure: result held, next operand offered but refused
    out_ready = 1'b0;
    xfer(16'h0010, 1'b0, 1'b1);
    chk_result("bp", 16'h0010, 1'b0, 1'b0);
    held_sum = 16'h0010;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0009;
    in_sub   = 1'b0;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", {31'd0, in_ready},  32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum",   {16'd0, out_sum},   {16'd0, held_sum});
      chk("bp_cout",  {31'd0, out_cout},  32'd0);
      chk("bp_ovf",   {31'd0, out_ovf},   32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_result("bp_next", 16'h0009, 1'b0, 1'b0);
    accept("bp_next");

    // Reset mid-burst
    xfer(16'h0001, 1'b0, 1'b0);
    xfer(16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmid_state", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("rmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rmid_sum",   {16'd0, out_sum},   32'd0);
    chk("rmid_ready", {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(16'h0002, 1'b0, 1'b1);
    chk_result("rmid_next", 16'h0002, 1'b0, 1'b0);
    accept("rmid_next");

    // Reset while a result is held
    out_ready = 1'b0;
    xfer(16'h7FFF, 1'b0, 1'b0);
    xfer(16'h0001, 1'b0, 1'b1);
    chk_result("rdone", exp_ovf_sum, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rdone_valid", {31'd0, out_valid}, 32'd0);
    chk("rdone_ovf",   {31'd0, out_ovf},   32'd0);
    chk("rdone_sum",   {16'd0, out_sum},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rdone_idle", {30'd0, dbg_state}, {30'd0, IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
